poly_vec_ntt_seq: RTL and testbench



---
 rtl/poly_vec_ntt_seq.sv | 237 +++++++++++++++++++++++
 tb/tb_poly_vec_ntt_seq.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_vec_ntt_seq.sv
// poly_vec_ntt_seq
// Streams a vector of K polynomials, one at a time, through a single serial
// NTT core. For each polynomial it serialises operand A (and B for PWM) into
// the core, issues one start strobe, waits for the core's done pulse, requests
// a read-back and stores N result coefficients into the result vector.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   start_i, mode_i     start request (sampled in IDLE), 0 NTT / 1 PWM / 2 INTT / 3 reserved
//   vec_a_i, vec_b_i    operand vectors, poly k coeff j at [(k*N+j)*W +: W]
//   busy_o, done_o      busy while not idle; one-cycle completion pulse
//   err_o               sticky error (reserved mode or core watchdog expiry)
//   vec_c_o             result vector, same layout as the operands
//   core_*              serial load / start / done / read interface to the core
module poly_vec_ntt_seq #(
    parameter int K        = 2,
    parameter int N        = 256,
    parameter int W        = 12,
    parameter int Q        = 3329,
    parameter int READ_LAT = 1,
    parameter int TIMEOUT  = 4096
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       mode_i,
    input  logic [K*N*W-1:0] vec_a_i,
    input  logic [K*N*W-1:0] vec_b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [K*N*W-1:0] vec_c_o,
    output logic             core_load_a_o,
    output logic             core_load_b_o,
    output logic [W-1:0]     core_din_o,
    output logic             core_start_ntt_o,
    output logic             core_start_pwm_o,
    output logic             core_start_intt_o,
    input  logic             core_done_i,
    output logic             core_read_o,
    input  logic [W-1:0]     core_dout_i
);

    localparam int VW = K * N * W;
    localparam int IW = $clog2(VW);
    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam int JW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] MODE_NTT  = 2'd0;
    localparam logic [1:0] MODE_PWM  = 2'd1;
    localparam logic [1:0] MODE_INTT = 2'd2;
    localparam logic [1:0] MODE_RSVD = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD_A, S_LOAD_B, S_GO, S_WAIT, S_RD_REQ, S_RD, S_DONE, S_ERR
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      mode_q, mode_d;
    logic [KW-1:0]   k_q, k_d;
    logic [JW-1:0]   j_q, j_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [VW-1:0]   a_q, a_d, b_q, b_d, c_q, c_d;
    logic            err_q, err_d, done_q, done_d, busy_q, busy_d;
    logic            load_a_q, load_a_d, load_b_q, load_b_d;
    logic            st_ntt_q, st_ntt_d, st_pwm_q, st_pwm_d, st_intt_q, st_intt_d;
    logic            read_q, read_d;
    logic [W-1:0]    din_q, din_d;
    logic [IW-1:0]   wr_base, rd_base;

    // Negative (two's complement) inputs are lifted into [0, Q) range by adding
    // Q, wrapping modulo 2^W.
    function automatic logic [W-1:0] in_corr(input logic signed [W-1:0] coef);
        logic [W-1:0] q_w;
        q_w = W'(Q);
        if (coef < 0) return $unsigned(coef) + q_w;
        return $unsigned(coef);
    endfunction

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        k_d     = k_q;
        j_d     = j_q;
        timer_d = timer_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        err_d   = err_q;
        wr_base = IW'((int'(k_q) * N + int'(j_q)) * W);

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (mode_i == MODE_RSVD) begin
                        state_d = S_ERR;
                    end else begin
                        a_d     = vec_a_i;
                        b_d     = vec_b_i;
                        mode_d  = mode_i;
                        err_d   = 1'b0;
                        k_d     = '0;
                        j_d     = '0;
                        state_d = S_LOAD_A;
                    end
                end
            end
            S_LOAD_A: begin
                if (j_q == JW'(N - 1)) begin
                    j_d     = '0;
                    state_d = (mode_q == MODE_PWM) ? S_LOAD_B : S_GO;
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            S_LOAD_B: begin
                if (j_q == JW'(N - 1)) begin
                    j_d     = '0;
                    state_d = S_GO;
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            S_GO: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (core_done_i) begin
                    state_d = S_RD_REQ;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    state_d = S_ERR;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_RD_REQ: begin
                timer_d = '0;
                j_d     = '0;
                state_d = S_RD;
            end
            S_RD: begin
                // timer counts off the read latency, then j walks the N stores.
                if (timer_q == TW'(READ_LAT - 1)) begin
                    c_d[wr_base +: W] = core_dout_i;
                    if (j_q == JW'(N - 1)) begin
                        j_d = '0;
                        if (k_q == KW'(K - 1)) begin
                            state_d = S_DONE;
                        end else begin
                            k_d     = k_q + 1'b1;
                            state_d = S_LOAD_A;
                        end
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_ERR) err_d = 1'b1;

        // Outputs are registered, so they are derived from the next state and
        // next indices; a_d/b_d already hold the freshly captured operands.
        rd_base   = IW'((int'(k_d) * N + int'(j_d)) * W);
        din_d     = '0;
        if (state_d == S_LOAD_A)      din_d = in_corr(a_d[rd_base +: W]);
        else if (state_d == S_LOAD_B) din_d = in_corr(b_d[rd_base +: W]);
        load_a_d  = (state_d == S_LOAD_A);
        load_b_d  = (state_d == S_LOAD_B);
        st_ntt_d  = (state_d == S_GO) && (mode_d == MODE_NTT);
        st_pwm_d  = (state_d == S_GO) && (mode_d == MODE_PWM);
        st_intt_d = (state_d == S_GO) && (mode_d == MODE_INTT);
        read_d    = (state_d == S_RD_REQ);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE) || (state_d == S_ERR);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            j_q       <= '0;
            timer_q   <= '0;
            c_q       <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            load_a_q  <= 1'b0;
            load_b_q  <= 1'b0;
            st_ntt_q  <= 1'b0;
            st_pwm_q  <= 1'b0;
            st_intt_q <= 1'b0;
            read_q    <= 1'b0;
            din_q     <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            j_q       <= j_d;
            timer_q   <= timer_d;
            c_q       <= c_d;
            err_q     <= err_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            load_a_q  <= load_a_d;
            load_b_q  <= load_b_d;
            st_ntt_q  <= st_ntt_d;
            st_pwm_q  <= st_pwm_d;
            st_intt_q <= st_intt_d;
            read_q    <= read_d;
            din_q     <= din_d;
        end
        // Operand latches carry data only and need no reset.
        a_q    <= a_d;
        b_q    <= b_d;
        mode_q <= mode_d;
    end

    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign err_o             = err_q;
    assign vec_c_o           = c_q;
    assign core_load_a_o     = load_a_q;
    assign core_load_b_o     = load_b_q;
    assign core_din_o        = din_q;
    assign core_start_ntt_o  = st_ntt_q;
    assign core_start_pwm_o  = st_pwm_q;
    assign core_start_intt_o = st_intt_q;
    assign core_read_o       = read_q;

endmodule

// File: tb/tb_poly_vec_ntt_seq.sv
// Testbench for poly_vec_ntt_seq: a behavioural stub core (done after L WAIT
// cycles, read latency 1, echo din+1 or (a*b) mod Q) plus directed scenarios.
module tb_poly_vec_ntt_seq;
    localparam int K  = 2;
    localparam int N  = 256;
    localparam int W  = 12;
    localparam int Q  = 3329;
    localparam int VW = K * N * W;
    localparam int IW = $clog2(VW);
    localparam int NB = $clog2(N);
    localparam int LB = $clog2(K * N);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [VW-1:0] vec_a, vec_b, vec_c;
    logic          busy, done, err;
    logic          core_load_a, core_load_b, core_start_ntt, core_start_pwm, core_start_intt;
    logic          core_done = 1'b0, core_read;
    logic [W-1:0]  core_din, core_dout = '0;

    always #5 clk = ~clk;

    poly_vec_ntt_seq dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode),
        .vec_a_i(vec_a), .vec_b_i(vec_b),
        .busy_o(busy), .done_o(done), .err_o(err), .vec_c_o(vec_c),
        .core_load_a_o(core_load_a), .core_load_b_o(core_load_b), .core_din_o(core_din),
        .core_start_ntt_o(core_start_ntt), .core_start_pwm_o(core_start_pwm),
        .core_start_intt_o(core_start_intt), .core_done_i(core_done),
        .core_read_o(core_read), .core_dout_i(core_dout)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Stub core state
    logic [W-1:0] sa [N];
    logic [W-1:0] sb [N];
    logic [W-1:0] a_log [K*N];
    int sa_n = 0, sb_n = 0, rd_idx = 0, wait_cnt = 0, stub_L = 10;
    bit rd_act = 0, stub_pwm = 0;
    int n_load_a = 0, n_load_b = 0, n_ntt = 0, n_pwm = 0, n_intt = 0, n_read = 0;

    function automatic logic [W-1:0] stub_res(input int i);
        int a, b;
        a = int'(sa[NB'(i)]);
        b = int'(sb[NB'(i)]);
        if (stub_pwm) return W'((a * b) % Q);
        return W'((a + 1) % 4096);
    endfunction

    always @(negedge clk) begin
        core_done = 1'b0;
        if (rst) begin
            wait_cnt = 0; rd_act = 0; sa_n = 0; sb_n = 0;
        end else begin
            if (wait_cnt != 0) begin
                wait_cnt--;
                if (wait_cnt == 0) core_done = 1'b1;
            end
            if (core_start_ntt || core_start_pwm || core_start_intt) begin
                wait_cnt = stub_L; stub_pwm = core_start_pwm; sa_n = 0; sb_n = 0;
                if (core_start_ntt)  n_ntt++;
                if (core_start_pwm)  n_pwm++;
                if (core_start_intt) n_intt++;
            end
            if (rd_act) begin
                core_dout = stub_res(rd_idx);
                rd_idx++;
                if (rd_idx == N) rd_act = 0;
            end
            if (core_read) begin rd_act = 1; rd_idx = 0; n_read++; end
            if (core_load_a) begin
                sa[NB'(sa_n)] = core_din; a_log[LB'(n_load_a)] = core_din;
                sa_n++; n_load_a++;
            end
            if (core_load_b) begin sb[NB'(sb_n)] = core_din; sb_n++; n_load_b++; end
        end
    end

    // Reference input correction: values with the sign bit set get +Q mod 4096.
    function automatic int ref_corr(input logic [W-1:0] c);
        if (c >= 12'h800) return int'(c) + Q - 4096;
        return int'(c);
    endfunction

    function automatic int model_mismatches(input bit pwm);
        int bad;
        bad = 0;
        for (int i = 0; i < K * N; i++) begin
            int a, b, e;
            a = ref_corr(vec_a[IW'(i * W) +: W]);
            b = ref_corr(vec_b[IW'(i * W) +: W]);
            e = pwm ? (a * b) % Q : (a + 1) % 4096;
            if (int'(vec_c[IW'(i * W) +: W]) != e) bad++;
        end
        return bad;
    endfunction

    task automatic run_op(input logic [1:0] m, input int limit, input int glitch,
                          output int done_cyc, output logic err_at_done,
                          output logic err_c1, output logic busy_at_done);
        int cyc;
        @(negedge clk); start = 1'b1; mode = m;
        @(negedge clk); start = 1'b0; cyc = 1;
        err_c1 = err; done_cyc = -1; err_at_done = 1'b0; busy_at_done = 1'b0;
        while (cyc <= limit) begin
            if (done) begin
                done_cyc = cyc; err_at_done = err; busy_at_done = busy;
                break;
            end
            start = (cyc == glitch);
            mode  = (cyc == glitch) ? 2'd1 : m;
            @(negedge clk); cyc++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done got=%b want=0", done); end
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL reset_err got=%b want=0", err); end
        n_checks++; if ({core_load_a, core_load_b, core_start_ntt, core_start_pwm, core_start_intt, core_read} !== 6'b0)
            begin n_errors++; $display("FAIL reset_strobes got=%b want=0", {core_load_a, core_load_b, core_start_ntt, core_start_pwm, core_start_intt, core_read}); end
        n_checks++; if (core_din !== '0) begin n_errors++; $display("FAIL reset_din got=%0d want=0", core_din); end
        n_checks++; if (vec_c !== '0) begin n_errors++; $display("FAIL reset_vec_c got nonzero want=0"); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ntt();
        int dc, la, lb, nt, pw, it, rd, mm;
        logic ed, e1, bd;
        la = n_load_a; lb = n_load_b; nt = n_ntt; pw = n_pwm; it = n_intt; rd = n_read;
        run_op(2'd0, 3000, -1, dc, ed, e1, bd);
        n_checks++; if (dc !== 1049) begin n_errors++; $display("FAIL ntt_done_cycle got=%0d want=1049", dc); end
        n_checks++; if (ed !== 1'b0) begin n_errors++; $display("FAIL ntt_err got=%b want=0", ed); end
        n_checks++; if (n_load_a - la !== 512) begin n_errors++; $display("FAIL ntt_load_a got=%0d want=512", n_load_a - la); end
        n_checks++; if (n_load_b - lb !== 0) begin n_errors++; $display("FAIL ntt_load_b got=%0d want=0", n_load_b - lb); end
        n_checks++; if (n_ntt - nt !== 2) begin n_errors++; $display("FAIL ntt_starts got=%0d want=2", n_ntt - nt); end
        n_checks++; if ((n_pwm - pw) + (n_intt - it) !== 0) begin n_errors++; $display("FAIL ntt_other_starts got=%0d want=0", (n_pwm - pw) + (n_intt - it)); end
        n_checks++; if (n_read - rd !== 2) begin n_errors++; $display("FAIL ntt_reads got=%0d want=2", n_read - rd); end
        mm = model_mismatches(1'b0);
        n_checks++; if (mm !== 0) begin n_errors++; $display("FAIL ntt_vec_c mismatching_coeffs got=%0d want=0", mm); end
        n_checks++; if (a_log[0] !== 12'd3328) begin n_errors++; $display("FAIL corr_fff got=%0d want=3328", a_log[0]); end
        n_checks++; if (a_log[1] !== 12'd5) begin n_errors++; $display("FAIL corr_5 got=%0d want=5", a_log[1]); end
        n_checks++; if (a_log[2] !== 12'd1281) begin n_errors++; $display("FAIL corr_800 got=%0d want=1281", a_log[2]); end
        n_checks++; if (a_log[3] !== 12'd2047) begin n_errors++; $display("FAIL corr_7ff got=%0d want=2047", a_log[3]); end
        @(negedge clk);
        n_checks++; if ({done, busy} !== 2'b00) begin n_errors++; $display("FAIL ntt_after got done,busy=%b want=00", {done, busy}); end
    endtask

    task automatic test_pwm();
        int dc, la, lb, nt, pw, mm;
        logic ed, e1, bd;
        la = n_load_a; lb = n_load_b; nt = n_ntt; pw = n_pwm;
        run_op(2'd1, 3000, -1, dc, ed, e1, bd);
        n_checks++; if (dc !== 1561) begin n_errors++; $display("FAIL pwm_done_cycle got=%0d want=1561", dc); end
        n_checks++; if (n_load_a - la !== 512) begin n_errors++; $display("FAIL pwm_load_a got=%0d want=512", n_load_a - la); end
        n_checks++; if (n_load_b - lb !== 512) begin n_errors++; $display("FAIL pwm_load_b got=%0d want=512", n_load_b - lb); end
        n_checks++; if (n_pwm - pw !== 2) begin n_errors++; $display("FAIL pwm_starts got=%0d want=2", n_pwm - pw); end
        n_checks++; if (n_ntt - nt !== 0) begin n_errors++; $display("FAIL pwm_ntt_starts got=%0d want=0", n_ntt - nt); end
        mm = model_mismatches(1'b1);
        n_checks++; if (mm !== 0) begin n_errors++; $display("FAIL pwm_vec_c mismatching_coeffs got=%0d want=0", mm); end
    endtask

    task automatic test_intt();
        int dc, it, nt, mm;
        logic ed, e1, bd;
        it = n_intt; nt = n_ntt;
        run_op(2'd2, 3000, -1, dc, ed, e1, bd);
        n_checks++; if (dc !== 1049) begin n_errors++; $display("FAIL intt_done_cycle got=%0d want=1049", dc); end
        n_checks++; if (n_intt - it !== 2) begin n_errors++; $display("FAIL intt_starts got=%0d want=2", n_intt - it); end
        n_checks++; if (n_ntt - nt !== 0) begin n_errors++; $display("FAIL intt_ntt_starts got=%0d want=0", n_ntt - nt); end
        mm = model_mismatches(1'b0);
        n_checks++; if (mm !== 0) begin n_errors++; $display("FAIL intt_vec_c mismatching_coeffs got=%0d want=0", mm); end
    endtask

    task automatic test_timeout();
        int dc, rd, mm;
        logic ed, e1, bd;
        stub_L = 0;
        rd = n_read;
        run_op(2'd0, 6000, -1, dc, ed, e1, bd);
        stub_L = 10;
        n_checks++; if (dc !== 4354) begin n_errors++; $display("FAIL timeout_done_cycle got=%0d want=4354", dc); end
        n_checks++; if (ed !== 1'b1) begin n_errors++; $display("FAIL timeout_err got=%b want=1", ed); end
        n_checks++; if (bd !== 1'b1) begin n_errors++; $display("FAIL timeout_busy_in_err got=%b want=1", bd); end
        n_checks++; if (n_read - rd !== 0) begin n_errors++; $display("FAIL timeout_reads got=%0d want=0", n_read - rd); end
        mm = model_mismatches(1'b0);
        n_checks++; if (mm !== 0) begin n_errors++; $display("FAIL timeout_vec_c_hold mismatching_coeffs got=%0d want=0", mm); end
        @(negedge clk);
        n_checks++; if ({err, done, busy} !== 3'b100) begin n_errors++; $display("FAIL timeout_sticky got err,done,busy=%b want=100", {err, done, busy}); end
        run_op(2'd0, 3000, -1, dc, ed, e1, bd);
        n_checks++; if (e1 !== 1'b0) begin n_errors++; $display("FAIL err_clear_on_start got=%b want=0", e1); end
        n_checks++; if (dc !== 1049) begin n_errors++; $display("FAIL after_timeout_done_cycle got=%0d want=1049", dc); end
    endtask

    task automatic test_mode3();
        int dc, tot0, tot1;
        logic ed, e1, bd;
        tot0 = n_load_a + n_load_b + n_ntt + n_pwm + n_intt + n_read;
        run_op(2'd3, 20, -1, dc, ed, e1, bd);
        tot1 = n_load_a + n_load_b + n_ntt + n_pwm + n_intt + n_read;
        n_checks++; if (dc !== 1) begin n_errors++; $display("FAIL mode3_done_cycle got=%0d want=1", dc); end
        n_checks++; if (ed !== 1'b1) begin n_errors++; $display("FAIL mode3_err got=%b want=1", ed); end
        n_checks++; if (tot1 - tot0 !== 0) begin n_errors++; $display("FAIL mode3_strobes got=%0d want=0", tot1 - tot0); end
        @(negedge clk);
        n_checks++; if ({busy, done, err} !== 3'b001) begin n_errors++; $display("FAIL mode3_after got busy,done,err=%b want=001", {busy, done, err}); end
    endtask

    task automatic test_back_to_back();
        int dc, pw, mm;
        logic ed, e1, bd;
        pw = n_pwm;
        run_op(2'd0, 3000, 100, dc, ed, e1, bd);
        n_checks++; if (dc !== 1049) begin n_errors++; $display("FAIL busy_start_done_cycle got=%0d want=1049", dc); end
        n_checks++; if (n_pwm - pw !== 0) begin n_errors++; $display("FAIL busy_start_pwm got=%0d want=0", n_pwm - pw); end
        run_op(2'd1, 3000, 700, dc, ed, e1, bd);
        n_checks++; if (dc !== 1561) begin n_errors++; $display("FAIL b2b_pwm_done_cycle got=%0d want=1561", dc); end
        mm = model_mismatches(1'b1);
        n_checks++; if (mm !== 0) begin n_errors++; $display("FAIL b2b_pwm_vec_c mismatching_coeffs got=%0d want=0", mm); end
    endtask

    task automatic test_reset_mid();
        int dc, mm;
        logic ed, e1, bd;
        @(negedge clk); start = 1'b1; mode = 2'd1;
        @(negedge clk); start = 1'b0;
        repeat (299) @(negedge clk);
        n_checks++; if (core_load_b !== 1'b1) begin n_errors++; $display("FAIL mid_in_load_b got=%b want=1", core_load_b); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL mid_rst_busy got=%b want=0", busy); end
        n_checks++; if ({core_load_a, core_load_b, core_start_ntt, core_start_pwm, core_start_intt, core_read} !== 6'b0)
            begin n_errors++; $display("FAIL mid_rst_strobes got=%b want=0", {core_load_a, core_load_b, core_start_ntt, core_start_pwm, core_start_intt, core_read}); end
        n_checks++; if (vec_c !== '0) begin n_errors++; $display("FAIL mid_rst_vec_c got nonzero want=0"); end
        n_checks++; if ({done, err, core_din} !== 14'b0) begin n_errors++; $display("FAIL mid_rst_done_err_din got=%b want=0", {done, err, core_din}); end
        rst = 1'b0;
        run_op(2'd0, 3000, -1, dc, ed, e1, bd);
        n_checks++; if (dc !== 1049) begin n_errors++; $display("FAIL post_rst_done_cycle got=%0d want=1049", dc); end
        mm = model_mismatches(1'b0);
        n_checks++; if (mm !== 0) begin n_errors++; $display("FAIL post_rst_vec_c mismatching_coeffs got=%0d want=0", mm); end
    endtask

    initial begin
        for (int i = 0; i < K * N; i++) begin
            vec_a[IW'(i * W) +: W] = W'((i * 37 + 11) % 4096);
            vec_b[IW'(i * W) +: W] = W'((i * 53 + 7) % 4096);
        end
        vec_a[IW'(0)  +: W] = 12'hFFF;
        vec_a[IW'(12) +: W] = 12'd5;
        vec_a[IW'(24) +: W] = 12'h800;
        vec_a[IW'(36) +: W] = 12'h7FF;

        test_reset();
        test_ntt();
        test_pwm();
        test_intt();
        test_timeout();
        test_mode3();
        test_back_to_back();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
